find_top_bottom: RTL and testbench
==================================

# find_top_bottom

Upstream stage of `mapLeftandRight`. Given a seed pixel known to lie inside a shape, it walks the seed's column in the 60x60 image RAM upward and downward to find the shape's top and bottom rows. It then emits `mostTop`/`mostBottom`/`midPix` and a one-cycle `TopandBottomFound` pulse; the pulse restarts the left/right edge finders. The block drives the image RAM read port directly and never writes it.

## Interface
- `xSz`, 6: x coordinate width
- `ySz`, 6: y coordinate width
- `addrSz`, 12: RAM address width
- `colSz`, 3: pixel value width
- `x_resolution`, 60: image width; valid x is 0..59
- `y_resolution`, 60: image height; valid y is 0..59
- `THRESHOLD`, 0: background (black) pixel value

Ports:
- `clk` in 1: clock; all state changes on the rising edge
- `reset` in 1: asynchronous, active-high; clears all state immediately
- `start` in 1: launch request; sampled only in IDLE
- `seed_x` in xSz: seed column; sampled with `start`
- `seed_y` in ySz: seed row; sampled with `start`
- `busy` out 1: high in every state except IDLE
- `mem_address` out addrSz: RAM read address, `y_cnt*60 + x_reg`, combinational from registers
- `pix_val` in colSz: RAM output; synchronous RAM, valid one cycle after the address is presented
- `mostTop` out ySz: topmost non-background row of the seed column run
- `mostBottom` out ySz: bottommost non-background row of the run
- `midPix` out xSz: latched `seed_x`
- `TopandBottomFound` out 1: one-cycle done pulse

## Operation
- Registers: `x_reg`, `y_cnt`, `seed_y_r`, `mostTop`, `mostBottom`, `midPix`, and the state register. A pixel is "background" when `pix_val == THRESHOLD`.
- States: IDLE, UP_RD, UP_CHK, DN_RD, DN_CHK, FOUND.
- **IDLE**
  - On `start`=1 with `seed_x < 60` and `seed_y < 60`: load `x_reg`/`midPix` with `seed_x`; load `y_cnt`, `seed_y_r`, `mostTop`, `mostBottom` with `seed_y`; go to UP_RD.
  - Out-of-range seed: `start` is ignored and the block stays in IDLE.
- **UP_RD**: the address is presented; go to UP_CHK.
- **UP_CHK**
  - Non-background pixel: `mostTop <= y_cnt`. If `y_cnt == 0`, go to the down-init step. Otherwise `y_cnt <= y_cnt-1` and go to UP_RD.
  - Background pixel with `y_cnt == seed_y_r` (seed itself is background): go to FOUND; `mostTop = mostBottom = seed_y`.
  - Background pixel otherwise: go to the down-init step.
- **Down-init** (part of the UP_CHK transition, no extra cycle)
  - If `seed_y_r == 59`, go to FOUND.
  - Otherwise `y_cnt <= seed_y_r+1` and go to DN_RD.
- **DN_RD**: go to DN_CHK.
- **DN_CHK**
  - Non-background pixel: `mostBottom <= y_cnt`. If `y_cnt == 59`, go to FOUND. Otherwise `y_cnt <= y_cnt+1` and go to DN_RD.
  - Background pixel: go to FOUND.
- **FOUND**: `TopandBottomFound`=1 for this cycle only; go to IDLE.
- Outputs hold their values in IDLE until the next accepted `start`, so downstream sees them stable after the pulse falls.
- `start` during `busy` is ignored. `start` held high re-launches in the cycle after FOUND returns to IDLE.
- Arithmetic is unsigned. `y_cnt` never underflows past 0 or exceeds 59: both limits are checked before the counter steps.
- Address is computed as `{y,5'b0}+{y,4'b0}+{y,3'b0}+{y,2'b0}+x`, zero-extended to 12 bits.

## Timing
- Reset value of every output is 0: `busy`, `mostTop`, `mostBottom`, `midPix`, `TopandBottomFound`, and `mem_address` (since `x_reg = y_cnt = 0`). State resets to IDLE.
- Reset asserted mid-scan aborts at once: no `TopandBottomFound` is produced, and the block accepts `start` on the first edge after reset deasserts.
- Each pixel read costs 2 cycles (RD, then CHK).
- Let N be the number of pixels read. Let edge 0 be the edge that samples `start`.
  - `TopandBottomFound` rises after edge 2N and falls after edge 2N+1.
  - `busy` is high from after edge 0 until after edge 2N+1.
- `mostTop`/`mostBottom` are final no later than the edge that enters FOUND.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> all outputs 0 immediately; state IDLE; `busy`=0.
- Interior run: column 20, rows 10..30 non-background, others background; seed (20,15) -> N=23, pulse after edge 46, `mostTop`=10, `mostBottom`=30, `midPix`=20; `mem_address` sequence starts 920, 860.
- Full-column boundary: column 5 all non-background; seed (5,0) -> N=60, pulse after edge 120, `mostTop`=0, `mostBottom`=59; `y_cnt` never wraps.
- Background seed: pixel (7,7) background; seed (7,7) -> N=1, pulse after edge 2, `mostTop`=`mostBottom`=7, `midPix`=7.
- Handshake: pulse `start` with seed (40,40) while busy with the interior run -> no effect on outputs. Seed (60,3) from IDLE -> `busy` stays 0, no pulse.
- Reset mid-operation: reset during DN phase of the interior run -> no pulse; then `start` seed (20,15) -> identical result to the interior-run scenario.

Source files
------------

// File: rtl/find_top_bottom_if.sv
// find_top_bottom_if: launch handshake, image RAM read port and result bus of the column scanner
interface find_top_bottom_if #(
   parameter int xSz    = 6,
   parameter int ySz    = 6,
   parameter int addrSz = 12,
   parameter int colSz  = 3
);
   logic              start;
   logic [xSz-1:0]    seed_x;
   logic [ySz-1:0]    seed_y;
   logic              busy;
   logic [addrSz-1:0] mem_address;
   logic [colSz-1:0]  pix_val;
   logic [ySz-1:0]    mostTop;
   logic [ySz-1:0]    mostBottom;
   logic [xSz-1:0]    midPix;
   logic              TopandBottomFound;
   modport master (
      output start, seed_x, seed_y, pix_val,
      input  busy, mem_address, mostTop, mostBottom, midPix, TopandBottomFound
   );
   modport slave (
      input  start, seed_x, seed_y, pix_val,
      output busy, mem_address, mostTop, mostBottom, midPix, TopandBottomFound
   );
endinterface

// File: rtl/find_top_bottom.sv
// find_top_bottom: walks the seed column up then down to find the shape's top and bottom rows
module find_top_bottom #(
   parameter int xSz          = 6,
   parameter int ySz          = 6,
   parameter int addrSz       = 12,
   parameter int colSz        = 3,
   parameter int x_resolution = 60,
   parameter int y_resolution = 60,
   parameter logic [colSz-1:0] THRESHOLD = '0
) (
   input logic clk,
   input logic reset,
   find_top_bottom_if.slave bus
);
   localparam logic [xSz-1:0] X_MAX = xSz'(x_resolution - 1);
   localparam logic [ySz-1:0] Y_MAX = ySz'(y_resolution - 1);
   typedef enum logic [2:0] {IDLE, UP_RD, UP_CHK, DN_RD, DN_CHK, FOUND} state_t;
   state_t         r_state, w_state;
   logic [xSz-1:0] r_x, w_x, r_mid, w_mid;
   logic [ySz-1:0] r_y, w_y, r_seed_y, w_seed_y, r_top, w_top, r_bot, w_bot;
   logic           w_fg;
   assign w_fg                  = bus.pix_val != THRESHOLD;
   assign bus.busy              = r_state != IDLE;
   assign bus.TopandBottomFound = r_state == FOUND;
   assign bus.mostTop           = r_top;
   assign bus.mostBottom        = r_bot;
   assign bus.midPix            = r_mid;
   assign bus.mem_address       = addrSz'({r_y, 5'b0}) + addrSz'({r_y, 4'b0}) + addrSz'({r_y, 3'b0})
                                + addrSz'({r_y, 2'b0}) + addrSz'(r_x);
   // next state and register updates; the row limits are tested before y steps so it never wraps
   always_comb begin
      w_state  = r_state;
      w_x      = r_x;
      w_y      = r_y;
      w_seed_y = r_seed_y;
      w_top    = r_top;
      w_bot    = r_bot;
      w_mid    = r_mid;
      case (r_state)
         IDLE: if (bus.start && bus.seed_x <= X_MAX && bus.seed_y <= Y_MAX) begin
            w_x      = bus.seed_x;
            w_mid    = bus.seed_x;
            w_y      = bus.seed_y;
            w_seed_y = bus.seed_y;
            w_top    = bus.seed_y;
            w_bot    = bus.seed_y;
            w_state  = UP_RD;
         end
         UP_RD:  w_state = UP_CHK;
         UP_CHK: begin
            if (w_fg) w_top = r_y;
            if (w_fg && r_y != '0) begin
               w_y     = r_y - 1'b1;
               w_state = UP_RD;
            end else if (!w_fg && r_y == r_seed_y) w_state = FOUND;
            else if (r_seed_y == Y_MAX) w_state = FOUND;
            else begin
               w_y     = r_seed_y + 1'b1;
               w_state = DN_RD;
            end
         end
         DN_RD:  w_state = DN_CHK;
         DN_CHK: begin
            if (w_fg) w_bot = r_y;
            if (w_fg && r_y != Y_MAX) begin
               w_y     = r_y + 1'b1;
               w_state = DN_RD;
            end else w_state = FOUND;
         end
         default: w_state = IDLE;
      endcase
   end
   // state and datapath registers, cleared asynchronously so a reset aborts a scan at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_seed_y <= '0;
         r_top    <= '0;
         r_bot    <= '0;
         r_mid    <= '0;
      end else begin
         r_state  <= w_state;
         r_x      <= w_x;
         r_y      <= w_y;
         r_seed_y <= w_seed_y;
         r_top    <= w_top;
         r_bot    <= w_bot;
         r_mid    <= w_mid;
      end
   end
endmodule

// File: tb/tb_find_top_bottom.sv
// tb_find_top_bottom: directed and random column scans checked against a reference walk over an image array
module tb_find_top_bottom;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_assert = 0;
   int n_fail = 0;
   logic [2:0] img [3600];
   find_top_bottom_if bus ();
   find_top_bottom dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // synchronous image RAM: data appears one edge after the address
   always @(posedge clk) bus.pix_val <= img[bus.mem_address];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic logic fg(input int x, input int y);
      return img[y * 60 + x] != 3'd0;
   endfunction
   function automatic void model(input int sx, input int sy, output int top, output int bot, output int n);
      if (!fg(sx, sy)) begin
         top = sy;
         bot = sy;
         n   = 1;
         return;
      end
      top = sy;
      while (top > 0 && fg(sx, top - 1)) top--;
      bot = sy;
      while (bot < 59 && fg(sx, bot + 1)) bot++;
      n = (sy - top + 1) + (top > 0 ? 1 : 0) + (bot - sy) + (bot < 59 ? 1 : 0);
   endfunction
   task automatic clear_img();
      for (int i = 0; i < 3600; i++) img[i] = 3'd0;
   endtask
   task automatic run(input string tag, input int sx, input int sy, output int a0, output int a1);
      int top, bot, n, pe;
      logic busy_ok;
      model(sx, sy, top, bot, n);
      a0 = -1;
      a1 = -1;
      pe = -1;
      busy_ok = 1'b1;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.seed_x = 6'(sx);
      bus.seed_y = 6'(sy);
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int e = 0; e < 300; e++) begin
         @(negedge clk);
         if (e == 0) a0 = int'(bus.mem_address);
         if (e == 2) a1 = int'(bus.mem_address);
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (bus.TopandBottomFound === 1'b1) begin
            pe = e;
            break;
         end
      end
      chk({tag, " pulse_edge"}, pe, 2 * n);
      chk({tag, " busy_during"}, busy_ok, 1);
      chk({tag, " mostTop"}, bus.mostTop, top);
      chk({tag, " mostBottom"}, bus.mostBottom, bot);
      chk({tag, " midPix"}, bus.midPix, sx);
      @(negedge clk);
      chk({tag, " pulse_fall"}, bus.TopandBottomFound, 0);
      chk({tag, " busy_fall"}, bus.busy, 0);
      chk({tag, " top_hold"}, bus.mostTop, top);
   endtask
   initial begin
      int a0, a1;
      logic ok;
      bus.start  = 1'b0;
      bus.seed_x = '0;
      bus.seed_y = '0;
      clear_img();
      #7 reset = 1'b1;
      #1;
      chk("rst busy", bus.busy, 0);
      chk("rst pulse", bus.TopandBottomFound, 0);
      chk("rst top", bus.mostTop, 0);
      chk("rst bottom", bus.mostBottom, 0);
      chk("rst mid", bus.midPix, 0);
      chk("rst addr", bus.mem_address, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int y = 10; y <= 30; y++) img[y * 60 + 20] = 3'd5;
      fork
         run("interior", 20, 15, a0, a1);
         begin
            repeat (10) @(negedge clk);
            bus.start  = 1'b1;
            bus.seed_x = 6'd40;
            bus.seed_y = 6'd40;
            @(negedge clk);
            bus.start  = 1'b0;
         end
      join
      chk("interior addr0", a0, 920);
      chk("interior addr1", a1, 860);
      clear_img();
      for (int y = 0; y < 60; y++) img[y * 60 + 5] = 3'(1 + y % 7);
      run("fullcol", 5, 0, a0, a1);
      chk("fullcol addr0", a0, 5);
      clear_img();
      run("bgseed", 7, 7, a0, a1);
      chk("bgseed addr0", a0, 427);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.seed_x = 6'd60;
      bus.seed_y = 6'd3;
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.TopandBottomFound !== 1'b0) ok = 1'b0;
      end
      bus.start = 1'b0;
      chk("oor idle", ok, 1);
      for (int y = 10; y <= 30; y++) img[y * 60 + 20] = 3'd5;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.seed_x = 6'd20;
      bus.seed_y = 6'd15;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (20) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst busy", bus.busy, 0);
      chk("midrst top", bus.mostTop, 0);
      chk("midrst bottom", bus.mostBottom, 0);
      chk("midrst addr", bus.mem_address, 0);
      ok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bus.TopandBottomFound !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
      end
      chk("midrst nopulse", ok, 1);
      reset = 1'b0;
      run("after_rst", 20, 15, a0, a1);
      chk("after_rst addr0", a0, 920);
      for (int t = 0; t < 10; t++) begin
         int dens, sx, sy;
         dens = $urandom_range(2, 12);
         for (int i = 0; i < 3600; i++)
            img[i] = ($urandom_range(dens - 1) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
         sx = $urandom_range(59);
         sy = $urandom_range(59);
         run($sformatf("rand%0d", t), sx, sy, a0, a1);
         chk($sformatf("rand%0d addr0", t), a0, sy * 60 + sx);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
